// File: rtl/aes_pkg.sv
`default_nettype none
// ============================================================================
// Module      : aes_pkg
// Description : Shared widths, FSM state encoding and timeout default for the
//               AES decryption sequencer and its helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package aes_pkg;

  localparam int NK          = 8;    // key length in 32-bit words
  localparam int NB          = 4;    // block size in 32-bit words
  localparam int NR          = 14;   // number of rounds
  localparam int KEY_W       = 32 * NK;
  localparam int BLK_W       = 32 * NB;
  localparam int SCHED_W     = 32 * NB * (NR + 1);
  localparam int TMO_DEFAULT = 1023; // max cycles to wait for an engine

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    KEY_EXP = 3'd1,
    READY   = 3'd2,
    DEC     = 3'd3,
    OUT     = 3'd4
  } state_t;

endpackage
`default_nettype wire

// File: rtl/seq_timeout_cnt.sv
`default_nettype none
// ============================================================================
// Module      : seq_timeout_cnt
// Description : Clearable saturating cycle counter with a terminal flag.
//               expire is raised during the TMO-th enabled cycle, so a caller
//               that acts on it leaves its wait state exactly TMO cycles after
//               entering it.
// Ports       : clk, rst   - clock / synchronous active-high reset
//               clear      - force count to zero on the next edge
//               en         - count this cycle
//               expire     - terminal cycle reached (combinational)
// Revision    : 1.0 - initial release
// ============================================================================
module seq_timeout_cnt #(
  parameter int TMO = 1023,
  parameter int W   = $clog2(TMO + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic en,
  output logic expire
);

  localparam logic [W-1:0] C_LAST = W'(TMO - 1);
  localparam logic [W-1:0] C_MAX  = W'(TMO);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (en && (count != C_MAX)) begin
      // saturate rather than wrap so a stuck engine can never re-arm
      count <= count + 1'b1;
    end
  end

  assign expire = en && (count >= C_LAST);

endmodule
`default_nettype wire

// File: rtl/aes_dec_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : aes_dec_sequencer
// Description : Control FSM for the AES decryption datapath. Runs the key
//               expansion engine once per key, holds the schedule, feeds one
//               ciphertext block at a time to the decryption core and returns
//               the plaintext with a valid/ready handshake. Every engine wait
//               is guarded by a timeout that sets a sticky error flag.
// Ports       : clk/rst                         - clock, sync active-high reset
//               key_in/key_load/key_ack         - key request handshake
//               cipher_in/cipher_valid/ready     - ciphertext handshake
//               msg_out/msg_valid/msg_ready     - plaintext handshake
//               ke_key/ke_in_valid/ke_out_valid/ke_w   - key expansion engine
//               dec_w/dec_cipher/dec_in_valid/dec_out_valid/dec_msg - decryptor
//               key_loaded/busy/error           - status
// Revision    : 1.0 - initial release
// ============================================================================
module aes_dec_sequencer
  import aes_pkg::*;
#(
  parameter int nk  = aes_pkg::NK,
  parameter int nb  = aes_pkg::NB,
  parameter int nr  = aes_pkg::NR,
  parameter int TMO = aes_pkg::TMO_DEFAULT
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [32*nk-1:0]           key_in,
  input  logic                       key_load,
  output logic                       key_ack,
  input  logic [32*nb-1:0]           cipher_in,
  input  logic                       cipher_valid,
  output logic                       cipher_ready,
  output logic [32*nb-1:0]           msg_out,
  output logic                       msg_valid,
  input  logic                       msg_ready,
  output logic [32*nk-1:0]           ke_key,
  output logic                       ke_in_valid,
  input  logic                       ke_out_valid,
  input  logic [32*nb*(nr+1)-1:0]    ke_w,
  output logic [32*nb*(nr+1)-1:0]    dec_w,
  output logic [32*nb-1:0]           dec_cipher,
  output logic                       dec_in_valid,
  input  logic                       dec_out_valid,
  input  logic [32*nb-1:0]           dec_msg,
  output logic                       key_loaded,
  output logic                       busy,
  output logic                       error
);

  state_t state, state_next;

  logic load_key;
  logic load_sched;
  logic load_cipher;
  logic load_msg;
  logic set_error;
  logic tmo_en;
  logic tmo_clear;
  logic tmo_expire;

  // Counter runs only in the two engine-wait states and restarts from zero
  // on every state change, so each wait gets a fresh budget.
  assign tmo_en    = (state == KEY_EXP) || (state == DEC);
  assign tmo_clear = !tmo_en || (state_next != state);

  seq_timeout_cnt #(
    .TMO (TMO)
  ) u_tmo (
    .clk    (clk),
    .rst    (rst),
    .clear  (tmo_clear),
    .en     (tmo_en),
    .expire (tmo_expire)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next   = state;
    key_ack      = 1'b0;
    cipher_ready = 1'b0;
    ke_in_valid  = 1'b0;
    dec_in_valid = 1'b0;
    msg_valid    = 1'b0;
    busy         = 1'b0;
    load_key     = 1'b0;
    load_sched   = 1'b0;
    load_cipher  = 1'b0;
    load_msg     = 1'b0;
    set_error    = 1'b0;

    case (state)
      IDLE: begin
        key_ack = key_load && !rst;
        if (key_ack) begin
          load_key   = 1'b1;
          state_next = KEY_EXP;
        end
      end

      KEY_EXP: begin
        ke_in_valid = 1'b1;
        busy        = 1'b1;
        // a completion arriving on the terminal cycle still wins
        if (ke_out_valid) begin
          load_sched = 1'b1;
          state_next = READY;
        end else if (tmo_expire) begin
          set_error  = 1'b1;
          state_next = IDLE;
        end
      end

      READY: begin
        // a key request blocks ciphertext so a new key always wins a tie
        key_ack      = key_load && !rst;
        cipher_ready = !key_load && !rst;
        if (key_ack) begin
          load_key   = 1'b1;
          state_next = KEY_EXP;
        end else if (cipher_valid && cipher_ready) begin
          load_cipher = 1'b1;
          state_next  = DEC;
        end
      end

      DEC: begin
        dec_in_valid = 1'b1;
        busy         = 1'b1;
        if (dec_out_valid) begin
          load_msg   = 1'b1;
          state_next = OUT;
        end else if (tmo_expire) begin
          set_error  = 1'b1;
          state_next = READY;
        end
      end

      OUT: begin
        msg_valid = 1'b1;
        busy      = 1'b1;
        if (msg_ready) begin
          state_next = READY;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ke_key     <= '0;
      dec_w      <= '0;
      dec_cipher <= '0;
      msg_out    <= '0;
      key_loaded <= 1'b0;
      error      <= 1'b0;
    end else begin
      if (load_key) begin
        ke_key     <= key_in;
        key_loaded <= 1'b0;
      end
      if (load_sched) begin
        dec_w      <= ke_w;
        key_loaded <= 1'b1;
      end
      if (load_cipher) begin
        dec_cipher <= cipher_in;
      end
      if (load_msg) begin
        msg_out <= dec_msg;
      end
      if (set_error) begin
        error <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_aes_dec_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_aes_dec_sequencer
// Description : Directed self-checking bench for aes_dec_sequencer. Acts as
//               the key expansion engine, the decryption core and the
//               SPI-side source/sink. Inputs change and outputs are sampled
//               on the falling clock edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_aes_dec_sequencer;
  import aes_pkg::*;

  localparam int TMO = TMO_DEFAULT;

  logic               clk = 1'b0;
  logic               rst;
  logic [KEY_W-1:0]   key_in;
  logic               key_load;
  logic               key_ack;
  logic [BLK_W-1:0]   cipher_in;
  logic               cipher_valid;
  logic               cipher_ready;
  logic [BLK_W-1:0]   msg_out;
  logic               msg_valid;
  logic               msg_ready;
  logic [KEY_W-1:0]   ke_key;
  logic               ke_in_valid;
  logic               ke_out_valid;
  logic [SCHED_W-1:0] ke_w;
  logic [SCHED_W-1:0] dec_w;
  logic [BLK_W-1:0]   dec_cipher;
  logic               dec_in_valid;
  logic               dec_out_valid;
  logic [BLK_W-1:0]   dec_msg;
  logic               key_loaded;
  logic               busy;
  logic               error;

  int errors = 0;
  int checks = 0;

  localparam logic [KEY_W-1:0] KEY1 =
    256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [KEY_W-1:0] KEY2 =
    256'hfedcba9876543210fedcba9876543210fedcba9876543210fedcba9876543210;
  localparam logic [BLK_W-1:0] CT = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [BLK_W-1:0] PT = 128'h00112233445566778899aabbccddeeff;
  localparam logic [BLK_W-1:0] CT_OTHER = 128'hdeadbeefdeadbeefdeadbeefdeadbeef;

  aes_dec_sequencer dut (
    .clk           (clk),
    .rst           (rst),
    .key_in        (key_in),
    .key_load      (key_load),
    .key_ack       (key_ack),
    .cipher_in     (cipher_in),
    .cipher_valid  (cipher_valid),
    .cipher_ready  (cipher_ready),
    .msg_out       (msg_out),
    .msg_valid     (msg_valid),
    .msg_ready     (msg_ready),
    .ke_key        (ke_key),
    .ke_in_valid   (ke_in_valid),
    .ke_out_valid  (ke_out_valid),
    .ke_w          (ke_w),
    .dec_w         (dec_w),
    .dec_cipher    (dec_cipher),
    .dec_in_valid  (dec_in_valid),
    .dec_out_valid (dec_out_valid),
    .dec_msg       (dec_msg),
    .key_loaded    (key_loaded),
    .busy          (busy),
    .error         (error)
  );

  always #5 clk = ~clk;

  // Wide values are reported by their low 128 bits to keep lines short.
  task automatic chk(input string tag, input logic [SCHED_W-1:0] obs,
                     input logic [SCHED_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h (low 128 bits)",
             tag, obs[127:0], exp[127:0]);
    end
  endtask

  // Distinct word per schedule slot: {tag, 8'h00, word index}.
  function automatic logic [SCHED_W-1:0] sched_pattern(input logic [7:0] tag);
    logic [SCHED_W-1:0] s;
    s = '0;
    for (int i = 0; i < SCHED_W / 32; i++) begin
      s[i*32 +: 32] = {tag, 8'h00, 16'(i)};
    end
    return s;
  endfunction

  task automatic chk_all_zero(input string pfx);
    chk({pfx, "_msg_out"},      SCHED_W'(msg_out),      '0);
    chk({pfx, "_dec_w"},        dec_w,                  '0);
    chk({pfx, "_dec_cipher"},   SCHED_W'(dec_cipher),   '0);
    chk({pfx, "_ke_key"},       SCHED_W'(ke_key),       '0);
    chk({pfx, "_key_ack"},      SCHED_W'(key_ack),      '0);
    chk({pfx, "_cipher_ready"}, SCHED_W'(cipher_ready), '0);
    chk({pfx, "_msg_valid"},    SCHED_W'(msg_valid),    '0);
    chk({pfx, "_ke_in_valid"},  SCHED_W'(ke_in_valid),  '0);
    chk({pfx, "_dec_in_valid"}, SCHED_W'(dec_in_valid), '0);
    chk({pfx, "_key_loaded"},   SCHED_W'(key_loaded),   '0);
    chk({pfx, "_busy"},         SCHED_W'(busy),         '0);
    chk({pfx, "_error"},        SCHED_W'(error),        '0);
  endtask

  initial begin
    logic [SCHED_W-1:0] sched1;
    logic [SCHED_W-1:0] sched2;
    int                 cycles;
    logic               seen_mv;

    sched1 = sched_pattern(8'hA5);
    sched2 = sched_pattern(8'h3C);

    rst = 1'b1; key_in = '0; key_load = 1'b0; cipher_in = '0;
    cipher_valid = 1'b0; msg_ready = 1'b0; ke_out_valid = 1'b0; ke_w = '0;
    dec_out_valid = 1'b0; dec_msg = '0;

    // ---- reset state ----
    repeat (2) @(negedge clk);
    chk_all_zero("rst");
    rst = 1'b0;

    // ---- IDLE refuses ciphertext ----
    cipher_in = CT; cipher_valid = 1'b1; #1;
    chk("idle_cipher_ready", SCHED_W'(cipher_ready), '0);
    @(negedge clk);
    cipher_valid = 1'b0;
    chk("idle_stays", SCHED_W'(busy), '0);

    // ---- key load and expansion ----
    key_in = KEY1; key_load = 1'b1; #1;
    chk("key_ack_idle", SCHED_W'(key_ack), 1);
    @(negedge clk);
    #1;
    chk("key_ack_in_kexp", SCHED_W'(key_ack), 0);
    key_load = 1'b0;
    chk("ke_in_valid", SCHED_W'(ke_in_valid), 1);
    chk("ke_key", SCHED_W'(ke_key), SCHED_W'(KEY1));
    chk("busy_kexp", SCHED_W'(busy), 1);
    repeat (19) @(negedge clk);
    chk("ke_in_valid_hold", SCHED_W'(ke_in_valid), 1);
    ke_out_valid = 1'b1; ke_w = sched1;
    @(negedge clk);
    ke_out_valid = 1'b0; ke_w = '0;
    chk("dec_w_load", dec_w, sched1);
    chk("key_loaded", SCHED_W'(key_loaded), 1);
    chk("busy_ready", SCHED_W'(busy), 0);
    chk("ke_in_valid_off", SCHED_W'(ke_in_valid), 0);

    // ---- stray done pulse in READY is ignored ----
    dec_out_valid = 1'b1; dec_msg = PT;
    @(negedge clk);
    dec_out_valid = 1'b0; dec_msg = '0;
    chk("stray_done_msg_valid", SCHED_W'(msg_valid), 0);

    // ---- FIPS-197 C.3 block ----
    cipher_in = CT; cipher_valid = 1'b1; #1;
    chk("ready_cipher_ready", SCHED_W'(cipher_ready), 1);
    @(negedge clk);
    cipher_valid = 1'b0;
    chk("dec_in_valid", SCHED_W'(dec_in_valid), 1);
    chk("dec_cipher", SCHED_W'(dec_cipher), SCHED_W'(CT));
    chk("dec_cipher_ready_off", SCHED_W'(cipher_ready), 0);
    repeat (14) @(negedge clk);
    dec_out_valid = 1'b1; dec_msg = PT; #1;
    chk("msg_valid_before", SCHED_W'(msg_valid), 0);
    @(negedge clk);
    dec_out_valid = 1'b0; dec_msg = '0;
    chk("msg_valid_rise", SCHED_W'(msg_valid), 1);
    chk("msg_out", SCHED_W'(msg_out), SCHED_W'(PT));
    chk("dec_in_valid_off", SCHED_W'(dec_in_valid), 0);

    // ---- backpressure: plaintext held, new ciphertext refused ----
    cipher_in = CT_OTHER; cipher_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("hold_msg_valid", SCHED_W'(msg_valid), 1);
      chk("hold_msg_out", SCHED_W'(msg_out), SCHED_W'(PT));
      chk("hold_cipher_ready", SCHED_W'(cipher_ready), 0);
    end
    msg_ready = 1'b1; cipher_valid = 1'b0;
    @(negedge clk);
    msg_ready = 1'b0;
    chk("release_msg_valid", SCHED_W'(msg_valid), 0);
    chk("release_busy", SCHED_W'(busy), 0);
    chk("release_cipher_ready", SCHED_W'(cipher_ready), 1);
    chk("dec_w_unchanged", dec_w, sched1);
    chk("dec_cipher_unchanged", SCHED_W'(dec_cipher), SCHED_W'(CT));

    // ---- key request beats ciphertext in READY ----
    key_in = KEY2; key_load = 1'b1; cipher_in = CT_OTHER; cipher_valid = 1'b1; #1;
    chk("prio_key_ack", SCHED_W'(key_ack), 1);
    chk("prio_cipher_ready", SCHED_W'(cipher_ready), 0);
    @(negedge clk);
    key_load = 1'b0; cipher_valid = 1'b0;
    chk("prio_ke_in_valid", SCHED_W'(ke_in_valid), 1);
    chk("prio_dec_in_valid", SCHED_W'(dec_in_valid), 0);
    chk("prio_key_loaded", SCHED_W'(key_loaded), 0);
    chk("prio_ke_key", SCHED_W'(ke_key), SCHED_W'(KEY2));
    chk("prio_dec_cipher", SCHED_W'(dec_cipher), SCHED_W'(CT));
    repeat (5) @(negedge clk);
    ke_out_valid = 1'b1; ke_w = sched2;
    @(negedge clk);
    ke_out_valid = 1'b0; ke_w = '0;
    chk("dec_w_reload", dec_w, sched2);
    chk("key_reloaded", SCHED_W'(key_loaded), 1);

    // ---- decryption timeout ----
    cipher_in = CT; cipher_valid = 1'b1;
    @(negedge clk);
    cipher_valid = 1'b0;
    chk("tmo_dec_entered", SCHED_W'(dec_in_valid), 1);
    cycles = 0; seen_mv = 1'b0;
    while (error !== 1'b1 && cycles < TMO + 20) begin
      @(negedge clk);
      cycles++;
      if (msg_valid === 1'b1) seen_mv = 1'b1;
    end
    chk("tmo_cycles", SCHED_W'(cycles), SCHED_W'(TMO));
    chk("tmo_error", SCHED_W'(error), 1);
    chk("tmo_no_msg", SCHED_W'(seen_mv), 0);
    chk("tmo_back_ready", SCHED_W'(dec_in_valid), 0);
    chk("tmo_cipher_ready", SCHED_W'(cipher_ready), 1);
    chk("tmo_key_kept", SCHED_W'(key_loaded), 1);
    repeat (3) @(negedge clk);
    chk("error_sticky", SCHED_W'(error), 1);

    // ---- reset in the middle of DEC ----
    cipher_valid = 1'b1;
    @(negedge clk);
    cipher_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("mid_dec_active", SCHED_W'(dec_in_valid), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_all_zero("mid_rst");
    cipher_in = CT_OTHER; cipher_valid = 1'b1; #1;
    chk("post_rst_cipher_ready", SCHED_W'(cipher_ready), 0);
    @(negedge clk);
    cipher_valid = 1'b0;
    chk("post_rst_dec_in_valid", SCHED_W'(dec_in_valid), 0);
    chk("post_rst_busy", SCHED_W'(busy), 0);
    chk("post_rst_dec_cipher", SCHED_W'(dec_cipher), '0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/aes_dec_sequencer.md
Name: aes_dec_sequencer

Overview:
- Control FSM for the AES decryption datapath: runs the key-expansion engine once per key, holds the expanded schedule, then feeds ciphertext blocks one at a time to the decryption core.
- Each plaintext result goes back out with a valid/ready handshake.
- Sits between the SPI subnode (key/cipher source, plaintext sink) and the keyExpansion/decryption instances.
- Replaces ad-hoc valid gluing with an explicit, timeout-guarded sequence.

Parameters:
- nk, 8, key length in 32-bit words.
- nb, 4, block size in 32-bit words.
- nr, 14, number of rounds.
- TMO, 1023, maximum cycles to wait for any engine done before flagging error (10-bit counter).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous active-high reset.
- key_in  in  32*nk  AES key, sampled on the key_load accept cycle.
- key_load  in  1  request to expand a new key; level, accepted when key_ack=1.
- key_ack  out  1  key_load accepted this cycle.
- cipher_in  in  32*nb  ciphertext block.
- cipher_valid  in  1  ciphertext offered.
- cipher_ready  out  1  sequencer accepts ciphertext this cycle.
- msg_out  out  32*nb  plaintext result register.
- msg_valid  out  1  plaintext available; held until msg_ready.
- msg_ready  in  1  downstream consumes plaintext.
- ke_key  out  32*nk  key register driven to keyExpansion.
- ke_in_valid  out  1  start/hold for keyExpansion.
- ke_out_valid  in  1  keyExpansion schedule complete.
- ke_w  in  32*nb*(nr+1)  expanded schedule from keyExpansion.
- dec_w  out  32*nb*(nr+1)  registered schedule to decryption.
- dec_cipher  out  32*nb  registered ciphertext to decryption.
- dec_in_valid  out  1  start/hold for decryption.
- dec_out_valid  in  1  decryption done.
- dec_msg  in  32*nb  decryption output.
- key_loaded  out  1  a valid schedule is held in dec_w.
- busy  out  1  FSM not in IDLE or READY.
- error  out  1  sticky timeout flag.

Behaviour:
- Reset (rst=1 at a clk edge), regardless of state:
  - FSM enters IDLE.
  - All outputs go to 0: msg_out, dec_w, dec_cipher, ke_key, every valid/ack/ready, key_loaded, busy, error.
  - Timeout counter clears and any pending key request is dropped.
- States:
  - IDLE: no key loaded. cipher_ready=0, key_ack=key_load. On accept: ke_key<=key_in, go KEY_EXP.
  - KEY_EXP: ke_in_valid=1, busy=1, counter increments each cycle.
    - ke_out_valid=1 -> dec_w<=ke_w, key_loaded<=1, counter clears, go READY.
    - Counter reaches TMO first -> error<=1, key_loaded<=0, go IDLE.
  - READY: key_ack=key_load, cipher_ready=!key_load.
    - key_load has priority when both requests are present: key_loaded<=0, ke_key<=key_in, go KEY_EXP.
    - Otherwise, cipher_valid&&cipher_ready -> dec_cipher<=cipher_in, go DEC.
  - DEC: dec_in_valid=1, busy=1, counter runs.
    - dec_out_valid=1 -> msg_out<=dec_msg, msg_valid<=1, go OUT.
    - Timeout -> error<=1, go READY with no output.
  - OUT: msg_valid=1, busy=1, msg_out stable. On msg_ready: msg_valid<=0, go READY.
    - msg_ready in the same cycle msg_valid rises is valid.
- Latency:
  - Cipher accept at cycle t -> dec_in_valid=1 from t+1.
  - dec_out_valid seen at cycle d -> msg_valid=1 from d+1.
  - Key accept at cycle k -> ke_in_valid=1 from k+1.
- key_load outside IDLE/READY: key_ack=0 and the request stays pending at the source. The schedule in dec_w never changes during DEC/OUT.
- ke_out_valid or dec_out_valid arriving in a state that does not wait for it is ignored.
- error is sticky until rst. It does not block further operation.
- Counter width is ceil(log2(TMO+1)); it saturates and never wraps.

Decomposition:
- Shared package aes_pkg:
  - Width constants KEY_W=32*nk, BLK_W=32*nb, SCHED_W=32*nb*(nr+1).
  - State enum {IDLE, KEY_EXP, READY, DEC, OUT}.
  - TMO default.
- One natural sub-module: seq_timeout_cnt, a clearable saturating counter with a terminal flag, reused for both wait states.

Test Plan:
- Key load 0x000102…1f; model ke_out_valid 20 cycles after ke_in_valid -> key_ack one cycle, dec_w equals ke_w, key_loaded=1, busy drops.
- Offer FIPS-197 C.3 ciphertext 0x8ea2b7ca516745bfeafc49904b496089; decryption model returns after 15 cycles -> msg_out=0x00112233445566778899aabbccddeeff, msg_valid 1 cycle after dec_out_valid.
- Hold msg_ready=0 for 10 cycles -> msg_valid and msg_out stable, cipher_ready=0. Then msg_ready=1 -> return to READY.
- In READY, assert key_load and cipher_valid in the same cycle -> key_ack=1, cipher_ready=0, KEY_EXP entered, key_loaded=0.
- Never assert dec_out_valid -> error=1 exactly TMO cycles after entering DEC, FSM returns to READY, msg_valid stays 0.
- Assert rst mid-DEC -> next cycle all outputs 0, FSM IDLE; a following cipher_valid is refused (cipher_ready=0).
